// File: rtl/ic_jpeg_pkg.sv
// Shared types and constants for the RGB-to-YCbCr line FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ic_jpeg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_TAIL,
        ST_FLUSH
    } state_t;

    localparam int LINE_PIXELS_DEF   = 1920;
    localparam int FRAME_LINES_DEF   = 1080;

    // Line FIFO geometry and status thresholds (show-ahead off).
    localparam int FIFO_DEPTH        = 8192;
    localparam int FIFO_WIDTHU       = 13;
    localparam int FIFO_ALMOST_EMPTY = 92;
    localparam int FIFO_ALMOST_FULL  = 8100;

endpackage

// File: rtl/ic_rgbtoycbcr_obuf.sv
// Small output buffer holding {eof, eol, data} between the line FIFO and the converter.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internally; the caller never pushes when count + inflight reads reach DEPTH.
module ic_rgbtoycbcr_obuf #(
    parameter int DEPTH = 4,
    parameter int W     = 34
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Ring buffer update; clear wins over a simultaneous push or pop.
    always_ff @(posedge clock) begin
        if (!reset_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ic_rgbtoycbcr_ff_ctrl.sv
// Flow controller around the RGB-to-YCbCr line FIFO: throttled write side, scheduled read side, abort flush.
// Latency: FIFO read to out_valid is 2 cycles; 1 pixel/clock sustained with out_ready high.
// Backpressure: in_ready drops on FIFO almost_full or during flush; reads stop when the output buffer would overflow.
module ic_rgbtoycbcr_ff_ctrl
    import ic_jpeg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LINE_PIXELS = LINE_PIXELS_DEF,
    parameter int FRAME_LINES = FRAME_LINES_DEF,
    parameter int OBUF_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof,
    input  logic              frame_abort,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_wrreq,
    output logic              fifo_rdreq,
    output logic              fifo_sclr,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic              fifo_almost_empty,
    input  logic              fifo_almost_full,
    output logic              busy,
    output logic              err_sticky
);

    localparam int COL_W = $clog2(LINE_PIXELS);
    localparam int ROW_W = $clog2(FRAME_LINES);
    localparam int CNT_W = $clog2(OBUF_DEPTH) + 1;
    localparam int IDX_W = FIFO_WIDTHU + 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_PIXELS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_LINES - 1);

    state_t            state;
    logic              flush_cnt;
    logic              sclr_q;
    logic              wr_done;
    logic              inflight;
    logic              err_q;
    logic [COL_W-1:0]  wr_col, wpix_col, cap_col, cpix_col;
    logic [ROW_W-1:0]  wr_row, wpix_row, cap_row, cpix_row;
    logic [IDX_W-1:0]  wr_idx, cap_idx, resync_idx;
    logic              resync_vld;
    logic [CNT_W-1:0]  obuf_count;
    logic [DATA_W+1:0] obuf_head;
    logic [DATA_W+1:0] cap_dat;
    logic              sof_misplaced, wr_last, rd_room;
    logic              out_fire, eof_fire, cap_sof, cap_eol, cap_eof;

    // Write side: sclr_q also covers the cycle right after reset so every output but sclr is 0 then.
    assign in_ready      = reset_n && !sclr_q && !fifo_almost_full && (state != ST_FLUSH);
    assign fifo_wrreq    = in_valid && in_ready;
    assign fifo_data     = in_data;
    assign fifo_sclr     = sclr_q;

    assign wpix_col      = in_sof ? '0 : wr_col;
    assign wpix_row      = in_sof ? '0 : wr_row;
    assign sof_misplaced = in_sof && ((wr_col != '0) || (wr_row != '0));
    assign wr_last       = (wpix_col == LAST_COL) && (wpix_row == LAST_ROW);

    // Read issue: never more reads outstanding than free buffer slots.
    assign rd_room    = ({1'b0, obuf_count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(OBUF_DEPTH);
    assign fifo_rdreq = ((state == ST_STREAM) || (state == ST_TAIL)) && !fifo_empty && rd_room;

    // Tagging of the word arriving from the FIFO. A misplaced sof realigns the write counters, so the
    // FIFO index of that word is remembered and the capture counters realign when it comes out.
    assign cap_sof  = resync_vld && (cap_idx == resync_idx);
    assign cpix_col = cap_sof ? '0 : cap_col;
    assign cpix_row = cap_sof ? '0 : cap_row;
    assign cap_eol  = (cpix_col == LAST_COL);
    assign cap_eof  = cap_eol && (cpix_row == LAST_ROW);
    assign cap_dat  = {cap_eof, cap_eol, fifo_q};

    assign out_valid  = (obuf_count != '0);
    assign out_data   = out_valid ? obuf_head[DATA_W-1:0] : '0;
    assign out_eol    = out_valid && obuf_head[DATA_W];
    assign out_eof    = out_valid && obuf_head[DATA_W+1];
    assign out_fire   = out_valid && out_ready;
    assign eof_fire   = out_fire && out_eof;
    assign busy       = (state == ST_FILL) || (state == ST_STREAM) || (state == ST_TAIL);
    assign err_sticky = err_q;

    ic_rgbtoycbcr_obuf #(
        .DEPTH (OBUF_DEPTH),
        .W     (DATA_W + 2)
    ) u_obuf (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (frame_abort),
        .push     (inflight),
        .push_dat (cap_dat),
        .pop      (out_ready),
        .head     (obuf_head),
        .count    (obuf_count)
    );

    // Read FSM; abort overrides every other event and starts the two-cycle flush.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            flush_cnt <= 1'b0;
            sclr_q    <= 1'b1;
        end else if (frame_abort) begin
            state     <= ST_FLUSH;
            flush_cnt <= 1'b0;
            sclr_q    <= 1'b1;
        end else begin
            sclr_q <= 1'b0;
            case (state)
                // Leftover words of a following frame written during TAIL also restart the fill.
                ST_IDLE:   if (fifo_wrreq || !fifo_empty) state <= ST_FILL;
                ST_FILL:   if (wr_done) state <= ST_TAIL;
                           else if (!fifo_almost_empty) state <= ST_STREAM;
                ST_STREAM: if (wr_done) state <= ST_TAIL;
                           else if (fifo_almost_empty) state <= ST_FILL;
                ST_TAIL:   if (eof_fire) state <= ST_IDLE;
                ST_FLUSH: begin
                    flush_cnt <= ~flush_cnt;
                    if (flush_cnt) state <= ST_IDLE;
                end
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Write position counters and end-of-frame-written flag.
    always_ff @(posedge clock) begin
        if (!reset_n || frame_abort) begin
            wr_col  <= '0;
            wr_row  <= '0;
            wr_idx  <= '0;
            wr_done <= 1'b0;
        end else begin
            if (eof_fire) wr_done <= 1'b0;
            if (fifo_wrreq) begin
                wr_idx <= wr_idx + IDX_W'(1);
                if (wpix_col == LAST_COL) begin
                    wr_col <= '0;
                    wr_row <= (wpix_row == LAST_ROW) ? '0 : wpix_row + ROW_W'(1);
                end else begin
                    wr_col <= wpix_col + COL_W'(1);
                    wr_row <= wpix_row;
                end
                if (wr_last) wr_done <= 1'b1;
            end
        end
    end

    // Read return tracking: one-cycle read latency plus capture-side position counters.
    always_ff @(posedge clock) begin
        if (!reset_n || frame_abort) begin
            inflight   <= 1'b0;
            cap_col    <= '0;
            cap_row    <= '0;
            cap_idx    <= '0;
            resync_vld <= 1'b0;
            resync_idx <= '0;
        end else begin
            inflight <= fifo_rdreq;
            if (inflight) begin
                cap_idx <= cap_idx + IDX_W'(1);
                if (cap_sof) resync_vld <= 1'b0;
                if (cpix_col == LAST_COL) begin
                    cap_col <= '0;
                    cap_row <= (cpix_row == LAST_ROW) ? '0 : cpix_row + ROW_W'(1);
                end else begin
                    cap_col <= cpix_col + COL_W'(1);
                    cap_row <= cpix_row;
                end
            end
            if (fifo_wrreq && sof_misplaced) begin
                resync_vld <= 1'b1;
                resync_idx <= wr_idx;
            end
        end
    end

    // Sticky protocol error: misplaced sof or a write into a full FIFO; only reset clears it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (fifo_wrreq && (sof_misplaced || fifo_full)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ic_rgbtoycbcr_ff_ctrl.sv
// Bench for the line FIFO controller: behavioural FIFO model, scoreboard on the output stream.
// Latency: n/a.
// Backpressure: exercised through out_ready stalls and a forced almost_full.
module tb_ic_rgbtoycbcr_ff_ctrl;
    import ic_jpeg_pkg::*;

    localparam int LP = 16;
    localparam int FL = 4;
    localparam int DW = 32;
    localparam int OD = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, in_sof;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_eol, out_eof;
    logic [DW-1:0] out_data;
    logic          frame_abort;
    logic [DW-1:0] fifo_data;
    logic          fifo_wrreq, fifo_rdreq, fifo_sclr;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_empty, fifo_full, fifo_almost_empty, fifo_almost_full;
    logic          busy, err_sticky;

    // Second instance with default geometry, used for the almost_empty fill threshold.
    logic          d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_eol, d_out_eof;
    logic [DW-1:0] d_in_data, d_out_data, d_fifo_data;
    logic          d_fifo_wrreq, d_fifo_rdreq, d_fifo_sclr;
    logic          d_busy, d_err_sticky;
    int            d_cnt = 0;
    int            d_wr_total = 0;

    int            checks = 0;
    int            errors = 0;
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] fq[$];
    int            fcount = 0;
    logic          af_force = 1'b0;
    int            m_col = 0;
    int            m_row = 0;
    int            rd_cnt = 0;
    bit            busy_pending = 0;
    logic [DW+1:0] e;
    bit            def_mon = 0;
    int            cyc = 0, ae_cyc = -1, rd_cyc = -1, cnt_at_rd = 0;

    always #5 clock = ~clock;

    ic_rgbtoycbcr_ff_ctrl #(
        .DATA_W(DW), .LINE_PIXELS(LP), .FRAME_LINES(FL), .OBUF_DEPTH(OD)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_eol(out_eol), .out_eof(out_eof), .frame_abort(frame_abort),
        .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_rdreq(fifo_rdreq),
        .fifo_sclr(fifo_sclr), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_almost_empty(fifo_almost_empty),
        .fifo_almost_full(fifo_almost_full), .busy(busy), .err_sticky(err_sticky)
    );

    ic_rgbtoycbcr_ff_ctrl dut_def (
        .clock(clock), .reset_n(reset_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_sof(1'b0),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_eol(d_out_eol), .out_eof(d_out_eof), .frame_abort(1'b0),
        .fifo_data(d_fifo_data), .fifo_wrreq(d_fifo_wrreq), .fifo_rdreq(d_fifo_rdreq),
        .fifo_sclr(d_fifo_sclr), .fifo_q(32'h0), .fifo_empty(d_cnt == 0),
        .fifo_full(d_cnt >= FIFO_DEPTH), .fifo_almost_empty(d_cnt < FIFO_ALMOST_EMPTY),
        .fifo_almost_full(d_cnt >= FIFO_ALMOST_FULL), .busy(d_busy), .err_sticky(d_err_sticky)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Line FIFO model, show-ahead off: q updates on the edge after rdreq.
    always @(posedge clock) begin
        if (fifo_sclr) begin
            fq.delete();
        end else begin
            if (fifo_rdreq && fq.size() > 0) fifo_q <= fq.pop_front();
            if (fifo_wrreq) fq.push_back(fifo_data);
        end
        fcount <= fq.size();
    end
    assign fifo_empty        = (fcount == 0);
    assign fifo_full         = (fcount >= FIFO_DEPTH);
    assign fifo_almost_empty = (fcount < FIFO_ALMOST_EMPTY);
    assign fifo_almost_full  = (fcount >= FIFO_ALMOST_FULL) || af_force;

    // Occupancy-only model for the default-geometry instance.
    always @(posedge clock) begin
        if (d_fifo_sclr) d_cnt <= 0;
        else d_cnt <= d_cnt + (d_fifo_wrreq ? 1 : 0) - (d_fifo_rdreq ? 1 : 0);
        if (d_fifo_wrreq) d_wr_total <= d_wr_total + 1;
    end

    // Output scoreboard and read counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (busy_pending) begin
            chk("busy_after_eof", busy, 0);
            busy_pending = 0;
        end
        if (reset_n && fifo_rdreq) rd_cnt++;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_out", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pix", {out_eof, out_eol, out_data}, e);
                if (e[DW+1]) begin
                    chk("busy_at_eof", busy, 1);
                    busy_pending = 1;
                end
            end
        end
        if (def_mon) begin
            cyc++;
            if (!(d_cnt < FIFO_ALMOST_EMPTY) && ae_cyc < 0) ae_cyc = cyc;
            if (d_fifo_rdreq && rd_cyc < 0) begin
                rd_cyc    = cyc;
                cnt_at_rd = d_cnt;
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic sof);
        bit   acc = 0;
        int   guard = 0;
        logic eol_b, eof_b;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!acc && guard < 500) begin
            @(negedge clock);
            acc = in_ready;
            if (acc) begin
                if (sof) begin
                    m_col = 0;
                    m_row = 0;
                end
                eol_b = (m_col == LP - 1);
                eof_b = eol_b && (m_row == FL - 1);
                exp_q.push_back({eof_b, eol_b, d});
                m_col++;
                if (m_col == LP) begin
                    m_col = 0;
                    m_row = (m_row == FL - 1) ? 0 : m_row + 1;
                end
            end
            guard++;
            @(posedge clock);
            #1;
        end
        chk("send_accepted", acc, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_run(input int base, input int n, input bit sof_first);
        for (int i = 0; i < n; i++) send(DW'(base + i), sof_first && (i == 0));
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clock);
            g++;
        end
        chk(tag, exp_q.size(), 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; in_sof = 1'b0;
        out_ready = 1'b0; frame_abort = 1'b0;
        d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wrreq", fifo_wrreq, 0);
        chk("rst_sclr", fifo_sclr, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rdreq", fifo_rdreq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_sticky, 0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("sclr_after_rst", fifo_sclr, 0);
        chk("ready_after_rst", in_ready, 1);
        @(posedge clock); #1;

        // One full frame streamed with the consumer always ready
        out_ready = 1'b1;
        send_run(0, 64, 1);
        drain("t1_drain");

        // Default geometry: no read until the FIFO holds the almost_empty cushion
        def_mon = 1;
        d_in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d_in_data = DW'(i);
            @(posedge clock); #1;
        end
        d_in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        def_mon = 0;
        chk("def_wr_total", d_wr_total, 100);
        chk("def_rd_seen", rd_cyc >= 0, 1);
        chk("def_rd_level", cnt_at_rd >= FIFO_ALMOST_EMPTY, 1);
        chk("def_rd_latency", (rd_cyc - ae_cyc) inside {[1:2]}, 1);

        // Consumer stalled: buffer fills, reads stop at its depth
        out_ready = 1'b0;
        rd_cnt = 0;
        send_run(100, 64, 1);
        repeat (50) @(posedge clock);
        #1;
        chk("t3_reads_stalled", rd_cnt, OD);
        chk("t3_out_valid", out_valid, 1);
        out_ready = 1'b1;
        drain("t3_drain");

        // almost_full throttles the write side while a pixel is held
        send_run(200, 20, 1);
        af_force = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd220;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("t4_in_ready", in_ready, 0);
            chk("t4_wrreq", fifo_wrreq, 0);
            @(posedge clock); #1;
        end
        af_force = 1'b0;
        send(32'd220, 1'b0);
        send_run(221, 43, 0);
        drain("t4_drain");

        // Abort mid-frame, then a clean frame
        send_run(300, 20, 1);
        frame_abort = 1'b1;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        @(posedge clock); #1;
        frame_abort = 1'b0;
        @(negedge clock);
        chk("t5_sclr_c1", fifo_sclr, 1);
        chk("t5_ready_c1", in_ready, 0);
        chk("t5_valid_c1", out_valid, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t5_sclr_c2", fifo_sclr, 0);
        chk("t5_ready_c2", in_ready, 0);
        chk("t5_valid_c2", out_valid, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t5_ready_back", in_ready, 1);
        @(posedge clock); #1;
        send_run(400, 64, 1);
        drain("t5_drain");

        // Misplaced sof: error flag, realigned line position
        chk("t6_err_before", err_sticky, 0);
        send_run(500, 5, 1);
        send_run(505, 64, 1);
        chk("t6_err_set", err_sticky, 1);
        drain("t6_drain");
        chk("t6_err_held", err_sticky, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
